// File: rtl/rr_decoder_arbiter.sv
// rtl/rr_decoder_arbiter.sv - round-robin arbiter driving a shared 2-to-4 decoder
module rr_decoder_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [3:0]       grant,
    output logic [1:0]       grant_idx,
    output logic             grant_valid,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [1:0]       last, last_nxt;
    logic [3:0]       grant_nxt;
    logic [1:0]       idx_nxt;
    logic             valid_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       pick_all, pick_oth;
    logic [3:0]       others;
    logic             new_grant, go_idle;
    logic [1:0]       win;

    // Returns {found, index}; scans ptr+1 .. ptr+4 and keeps the earliest hit.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] c;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            c = ptr + 2'(k);
            if (cand[c]) res = {1'b1, c};
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 2'd3;
            grant       <= 4'b0000;
            grant_idx   <= 2'd0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            grant       <= grant_nxt;
            grant_idx   <= idx_nxt;
            grant_valid <= valid_nxt;
            hold_cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        grant_nxt = grant;
        idx_nxt   = grant_idx;
        valid_nxt = grant_valid;
        cnt_nxt   = hold_cnt;
        new_grant = 1'b0;
        go_idle   = 1'b0;
        win       = 2'd0;
        // In BUSY the owner's bit is the only set bit of grant, so masking it leaves the contenders.
        others    = req & ~grant;
        pick_all  = rr_pick(req, last);
        pick_oth  = rr_pick(others, last);

        case (state)
            IDLE: begin
                if (pick_all[2]) begin
                    new_grant = 1'b1;
                    win       = pick_all[1:0];
                end
            end
            BUSY: begin
                if (!req[grant_idx]) begin
                    if (pick_oth[2]) begin
                        new_grant = 1'b1;
                        win       = pick_oth[1:0];
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (hold_cnt < CNT_W'(MAX_HOLD)) begin
                    cnt_nxt = hold_cnt + CNT_W'(1);
                end else if (pick_oth[2]) begin
                    new_grant = 1'b1;
                    win       = pick_oth[1:0];
                end else begin
                    cnt_nxt = CNT_W'(1);
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (new_grant) begin
            state_nxt = BUSY;
            grant_nxt = 4'b0001 << win;
            idx_nxt   = win;
            valid_nxt = 1'b1;
            cnt_nxt   = CNT_W'(1);
            last_nxt  = win;
        end else if (go_idle) begin
            state_nxt = IDLE;
            grant_nxt = 4'b0000;
            idx_nxt   = 2'd0;
            valid_nxt = 1'b0;
            cnt_nxt   = '0;
        end
    end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb/tb_rr_decoder_arbiter.sv - directed-vector bench for rr_decoder_arbiter
module tb_rr_decoder_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req2, req8, req1;

    logic [3:0] g2, g8, g1;
    logic [1:0] i2, i8, i1;
    logic       v2, v8, v1;
    logic [7:0] h2, h8, h1;

    int errors = 0;
    int checks = 0;

    rr_decoder_arbiter #(.MAX_HOLD(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .grant(g2),
        .grant_idx(i2), .grant_valid(v2), .hold_cnt(h2));
    rr_decoder_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .grant(g8),
        .grant_idx(i8), .grant_valid(v8), .hold_cnt(h8));
    rr_decoder_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .grant(g1),
        .grant_idx(i1), .grant_valid(v1), .hold_cnt(h1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk8(input string tag, input logic [3:0] g, input logic [7:0] h);
        check({tag, ".grant"}, 32'(g8), 32'(g));
        check({tag, ".hold"}, 32'(h8), 32'(h));
        check({tag, ".valid"}, 32'(v8), 32'(g != 4'b0000));
    endtask

    logic [3:0] seq2 [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                             4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [7:0] hs2  [9] = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1};

    initial begin
        rst_n = 1'b0;
        req2 = 4'b0000; req8 = 4'b0000; req1 = 4'b0000;
        step();
        step();
        check("rst.grant", 32'(g2), 32'h0);
        check("rst.idx", 32'(i2), 32'h0);
        check("rst.valid", 32'(v2), 32'h0);
        check("rst.hold", 32'(h2), 32'h0);

        // Full contention, MAX_HOLD=2.
        rst_n = 1'b1;
        req2  = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("rr2[%0d].grant", k), 32'(g2), 32'(seq2[k]));
            check($sformatf("rr2[%0d].hold", k), 32'(h2), 32'(hs2[k]));
        end
        req2 = 4'b0000;
        step();
        check("rr2.idle", 32'(v2), 32'h0);

        // Single requester 2 for three cycles.
        req8 = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk8($sformatf("r2[%0d]", k), 4'b0100, 8'(k));
            check($sformatf("r2[%0d].idx", k), 32'(i8), 32'd2);
        end
        req8 = 4'b0000;
        step();
        chk8("r2.drop", 4'b0000, 8'd0);

        // Owner 1 drops while 0 and 3 arrive; pointer at 1 favours 3.
        req8 = 4'b0010;
        step();
        chk8("ho.own1", 4'b0010, 8'd1);
        req8 = 4'b1001;
        step();
        chk8("ho.to3", 4'b1000, 8'd1);
        check("ho.idx", 32'(i8), 32'd3);
        req8 = 4'b0000;
        step();
        chk8("ho.idle", 4'b0000, 8'd0);

        // Lone requester 0 for 20 cycles: counter wraps, grant never drops.
        req8 = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk8($sformatf("wrap[%0d]", k), 4'b0001, 8'(((k - 1) % 8) + 1));
        end
        req8 = 4'b0000;
        step();
        chk8("wrap.idle", 4'b0000, 8'd0);

        // Reset mid-grant, then pointer restarts at 3.
        req8 = 4'b0100;
        for (int k = 0; k < 5; k++) step();
        chk8("mid.pre", 4'b0100, 8'd5);
        req8  = 4'b1111;
        rst_n = 1'b0;
        step();
        chk8("mid.rst", 4'b0000, 8'd0);
        check("mid.rst.idx", 32'(i8), 32'd0);
        rst_n = 1'b1;
        step();
        chk8("mid.after", 4'b0001, 8'd1);
        check("mid.after.idx", 32'(i8), 32'd0);
        req8 = 4'b0000;

        // MAX_HOLD=1 alternates every cycle.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req1  = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("h1[%0d].grant", k), 32'(g1), (k % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("h1[%0d].hold", k), 32'(h1), 32'd1);
        end
        req1 = 4'b0000;
        step();
        check("h1.idle", 32'(g1), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
